// File: rtl/mem_burst_seq.sv
// Burst request sequencer for one mem_interface_wr port: issues lockstep
// addr/wdata/wren tokens and accumulates read-return count and XOR checksum.
module mem_burst_seq #(
  parameter int unsigned AW      = 15,
  parameter int unsigned DW      = 31,
  parameter int unsigned LW      = 8,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_start,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_base,
  input  logic [LW-1:0] cmd_len,
  input  logic [DW-1:0] cmd_seed,
  output logic          busy,
  output logic          done,
  output logic [LW-1:0] rd_count,
  output logic [DW-1:0] rd_xor,
  output logic [AW:0]   addr,
  input  logic          addr_stop,
  output logic [DW:0]   wdata,
  input  logic          wdata_stop,
  output logic [1:0]    wren,
  input  logic          wren_stop,
  input  logic [DW:0]   rdata,
  output logic          rdata_stop
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t        state_q;
  logic          write_q;
  logic [AW-1:0] base_q;
  logic [LW-1:0] len_q;
  logic [DW-1:0] seed_q;
  logic [LW-1:0] idx_q;
  logic [LW-1:0] outst_q;
  logic          valid_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          busy_q;
  logic          done_q;
  logic [LW-1:0] rd_count_q;
  logic [DW-1:0] rd_xor_q;

  logic          accept;
  logic          ret;
  logic          last;
  logic          room;
  logic [LW-1:0] idx_d;
  logic [LW-1:0] outst_d;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] wdata_d;

  always_comb begin
    accept  = (state_q == S_ISSUE) && valid_q && !(addr_stop | wdata_stop | wren_stop);
    ret     = rdata[DW] && !write_q && ((state_q == S_ISSUE) || (state_q == S_DRAIN));
    last    = accept && (idx_q == len_q - LW'(1));
    idx_d   = idx_q + LW'(accept);
    outst_d = outst_q + LW'(accept) - LW'(ret);
    // Read bursts throttle on the post-edge outstanding count, so a return
    // arriving the same cycle frees a slot immediately.
    room    = write_q || (outst_d < LW'(MAX_OUT));
    addr_d  = base_q + AW'(idx_d);
    wdata_d = write_q ? (seed_q + DW'(idx_d)) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      write_q    <= 1'b0;
      base_q     <= '0;
      len_q      <= '0;
      seed_q     <= '0;
      idx_q      <= '0;
      outst_q    <= '0;
      valid_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_count_q <= '0;
      rd_xor_q   <= '0;
    end else begin
      if (ret) begin
        rd_count_q <= rd_count_q + LW'(1);
        rd_xor_q   <= rd_xor_q ^ rdata[DW-1:0];
      end
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (cmd_start) begin
            write_q    <= cmd_write;
            base_q     <= cmd_base;
            len_q      <= cmd_len;
            seed_q     <= cmd_seed;
            idx_q      <= '0;
            outst_q    <= '0;
            rd_count_q <= '0;
            rd_xor_q   <= '0;
            busy_q     <= 1'b1;
            addr_q     <= cmd_base;
            wdata_q    <= cmd_write ? cmd_seed : '0;
            // Zero-length bursts pass through DRAIN, whose exit test is already met.
            if (cmd_len == '0) begin
              state_q <= S_DRAIN;
            end else begin
              valid_q <= 1'b1;
              state_q <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          idx_q   <= idx_d;
          outst_q <= outst_d;
          if (last) begin
            valid_q <= 1'b0;
            if (write_q) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              state_q <= S_DRAIN;
            end
          end else if (!valid_q || accept) begin
            valid_q <= room;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
          end
        end
        S_DRAIN: begin
          outst_q <= outst_d;
          if (rd_count_q == len_q) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign rd_count   = rd_count_q;
  assign rd_xor     = rd_xor_q;
  assign addr       = valid_q ? {1'b1, addr_q} : '0;
  assign wdata      = valid_q ? {1'b1, wdata_q} : '0;
  assign wren       = valid_q ? {1'b1, write_q} : '0;
  assign rdata_stop = 1'b0;

endmodule
